// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified IF/MEM memory arbiter:
// FSM state encoding, default geometry and the word returned on a timeout abort.
`timescale 1ns/1ps
package mem_arb_pkg;

  // Default widths and policy limits
  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int MAX_WAIT_DEF     = 15;

  // Read data handed back to a requester whose access was aborted
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

  // Who currently owns the shared memory port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data requests.
// Data normally wins; after STARVE_LIMIT data grants taken while fetch was
// waiting, the next contended decision goes to fetch.
`timescale 1ns/1ps
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic dm_valid,
  input  logic grant_event,
  output logic pick_if,
  output logic pick_dm
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_reg;
  logic          starved;

  // Fetch is forced only when both want the port and fetch has waited long enough
  always_comb begin
    starved = (starve_cnt_reg == STARVE_MAX);
    pick_dm = dm_valid & (~if_valid | ~starved);
    pick_if = if_valid & ~pick_dm;
  end

  // Count data grants that overtook a waiting fetch; any fetch grant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (grant_event) begin
      if (pick_if) begin
        starve_cnt_reg <= '0;
      end else if (pick_dm && if_valid && !starved) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and data access. One access is in flight at a time: the grant cycle
// launches mem_req, completion (mem_ack or timeout) returns to IDLE with a
// one-cycle ready pulse to the owner. Stall holds the pipeline while either
// requester is still waiting.
`timescale 1ns/1ps
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int MAX_WAIT     = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data access side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // shared memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // pipeline control / status
  output logic              stall,
  output logic              timeout_err
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]     WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(TIMEOUT_RDATA);

  arb_state_t    state_reg;
  logic [WW-1:0] wait_cnt_reg;

  logic if_valid;
  logic dm_valid;
  logic grant_event;
  logic pick_if;
  logic pick_dm;
  logic access_done;
  logic access_abort;

  // A request seen together with its own ready pulse was already served
  always_comb begin
    if_valid     = if_req & ~if_ready;
    dm_valid     = dm_req & ~dm_ready;
    grant_event  = (state_reg == IDLE);
    access_done  = (state_reg != IDLE) & mem_ack;
    access_abort = (state_reg != IDLE) & ~mem_ack & (wait_cnt_reg == WAIT_LIMIT);
  end

  // Pipeline freezes until every raised request has seen its ready pulse
  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .dm_valid   (dm_valid),
    .grant_event(grant_event),
    .pick_if    (pick_if),
    .pick_dm    (pick_dm)
  );

  // Ownership FSM, memory handshake registers, ready pulses and timeout tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      if_ready     <= 1'b0;
      dm_ready     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // ready is a single-cycle pulse unless a completion re-asserts it below
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          // mem_ack arriving here belongs to nothing and is ignored
          if (pick_dm) begin
            state_reg    <= GNT_DM;
            mem_req      <= 1'b1;
            mem_we       <= dm_we;
            mem_addr     <= dm_addr;
            mem_wdata    <= dm_wdata;
            wait_cnt_reg <= '0;
          end else if (pick_if) begin
            state_reg    <= GNT_IF;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            wait_cnt_reg <= '0;
          end
        end

        GNT_IF: begin
          if (access_done || access_abort) begin
            if_ready     <= 1'b1;
            if_rdata     <= access_done ? mem_rdata : ABORT_DATA;
            state_reg    <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        GNT_DM: begin
          if (access_done || access_abort) begin
            dm_ready <= 1'b1;
            // stores keep the last load value; aborts always return the abort word
            if (access_abort) begin
              dm_rdata <= ABORT_DATA;
            end else if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            state_reg    <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase

      // an ack in the limit cycle is a normal completion, so only aborts flag
      if (access_abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus a randomized run,
// with a bench-side memory responder and a transaction-level model of who
// owns the memory and what each requester should receive.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_WAIT     = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        timeout_err;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: owner 0 = nobody, 1 = fetch, 2 = data
  int          m_owner, m_starve, m_wait;
  bit          m_if_rdy, m_dm_rdy, m_terr, m_req, m_we;
  logic [31:0] m_if_rdata, m_dm_rdata, m_addr, m_wdata;

  // memory responder
  logic [31:0] mem_arr [0:255];
  int          lat_cfg   = 1;   // ack in this mem_req cycle (1 = first); 0 = never
  int          age       = 0;
  bit          junk_idle = 0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_wait = 0;
    m_if_rdy = 0; m_dm_rdy = 0; m_terr = 0; m_req = 0; m_we = 0;
    m_if_rdata = 0; m_dm_rdata = 0; m_addr = 0; m_wdata = 0;
  endtask

  // What the clock edge about to happen should do, from the arbitration rules
  task automatic model_edge();
    bit ifv, dmv;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner == 0) begin
      ifv = if_req && !m_if_rdy;
      dmv = dm_req && !m_dm_rdy;
      m_if_rdy = 0; m_dm_rdy = 0;
      if (dmv && (!ifv || m_starve < STARVE_LIMIT)) begin
        m_owner = 2; m_req = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_wait = 0;
        if (ifv && m_starve < STARVE_LIMIT) m_starve++;
      end else if (ifv) begin
        m_owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_wait = 0; m_starve = 0;
      end
    end else begin
      m_if_rdy = 0; m_dm_rdy = 0;
      if (mem_ack || m_wait == MAX_WAIT) begin
        if (m_owner == 1) begin
          m_if_rdy = 1;
          m_if_rdata = mem_ack ? mem_rdata : 32'h0;
        end else begin
          m_dm_rdy = 1;
          if (!mem_ack) m_dm_rdata = 32'h0;
          else if (!m_we) m_dm_rdata = mem_rdata;
        end
        if (!mem_ack) m_terr = 1;
        m_owner = 0; m_req = 0; m_we = 0; m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  // One clock: memory write, model update, edge, then memory response for the new cycle
  task automatic tick();
    if (!rst && mem_req && mem_ack && mem_we) mem_arr[idx(mem_addr)] = mem_wdata;
    model_edge();
    @(posedge clk);
    #1;
    if (mem_req) begin
      age++;
      if (lat_cfg > 0 && age == lat_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[idx(mem_addr)];
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      age       = 0;
      mem_ack   = junk_idle ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; dm_req = 1; dm_we = 1; if_addr = 32'h44; dm_addr = 32'h88;
    dm_wdata = 32'hFFFF0000; mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    tick(); tick();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_tests++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    n_tests++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b/%b want 0/0", if_ready, dm_ready); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    rst = 0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fetch();
    int k;
    lat_cfg = 2; mem_arr[2] = 32'h8C220004;
    if_addr = 32'h8; if_req = 1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_req: got %b want 1", stall); end
    tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
    n_tests++; if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL fetch_mem_addr: got %h want 00000008", mem_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_we: got %b want 0", mem_we); end
    k = 1;
    while (!if_ready && k < 20) begin
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_wait: got %b want 1 at cycle %0d", stall, k); end
      tick(); k++;
    end
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d cycles want 3", k); end
    n_tests++; if (if_rdata !== 32'h8C220004) begin n_fail++; $display("FAIL fetch_rdata: got %h want 8c220004", if_rdata); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_ready: got %b want 0", stall); end
    if_req = 0;
    tick();
    n_tests++; if (if_ready !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_single_pulse: got ready=%b mem_req=%b want 0/0", if_ready, mem_req); end
    $display("[TB] test_fetch done in %0d cycles", k);
  endtask

  task automatic test_contention();
    int k;
    logic [31:0] dval, ival;
    dval = $urandom; ival = $urandom;
    mem_arr[idx(32'h100)] = dval; mem_arr[idx(32'h20)] = ival;
    lat_cfg = 2;
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    tick();
    n_tests++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin n_fail++; $display("FAIL contention_dm_first: got addr %h we %b want 00000100/0", mem_addr, mem_we); end
    k = 0;
    while (!dm_ready && k < 20) begin
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL contention_stall_dm: got %b want 1", stall); end
      n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL contention_if_early: got %b want 0", if_ready); end
      tick(); k++;
    end
    n_tests++; if (dm_rdata !== dval) begin n_fail++; $display("FAIL contention_dm_rdata: got %h want %h", dm_rdata, dval); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL contention_stall_gap: got %b want 1", stall); end
    dm_req = 0;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin n_fail++; $display("FAIL contention_if_grant: got req %b addr %h want 1/00000020", mem_req, mem_addr); end
    k = 0;
    while (!if_ready && k < 20) begin
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL contention_stall_if: got %b want 1", stall); end
      tick(); k++;
    end
    n_tests++; if (if_rdata !== ival) begin n_fail++; $display("FAIL contention_if_rdata: got %h want %h", if_rdata, ival); end
    if_req = 0;
    tick();
    $display("[TB] test_contention done");
  endtask

  task automatic test_store();
    logic [31:0] prev;
    prev = m_dm_rdata;
    lat_cfg = 3;
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL store_req_we: got %b/%b want 1/1 cycle %0d", mem_req, mem_we, i); end
      n_tests++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL store_wdata_addr: got %h/%h want 12345678/00000040", mem_wdata, mem_addr); end
      n_tests++; if (dm_ready !== 1'b0) begin n_fail++; $display("FAIL store_early_ready: got %b want 0 cycle %0d", dm_ready, i); end
      tick();
    end
    n_tests++; if (dm_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %b want 1", dm_ready); end
    n_tests++; if (dm_rdata !== prev) begin n_fail++; $display("FAIL store_rdata_kept: got %h want %h", dm_rdata, prev); end
    n_tests++; if (mem_arr[idx(32'h40)] !== 32'h12345678) begin n_fail++; $display("FAIL store_mem_written: got %h want 12345678", mem_arr[idx(32'h40)]); end
    dm_req = 0; dm_we = 0;
    tick();
    n_tests++; if (dm_ready !== 1'b0) begin n_fail++; $display("FAIL store_single_pulse: got %b want 0", dm_ready); end
    $display("[TB] test_store done");
  endtask

  task automatic test_ack_at_limit();
    int k;
    logic [31:0] val;
    val = $urandom; mem_arr[idx(32'h34)] = val;
    lat_cfg = MAX_WAIT + 1;
    if_req = 1; if_addr = 32'h34;
    k = 0;
    do begin tick(); k++; end while (!if_ready && k < 40);
    n_tests++; if (k !== MAX_WAIT + 2) begin n_fail++; $display("FAIL limit_latency: got %0d want %0d", k, MAX_WAIT + 2); end
    n_tests++; if (if_rdata !== val) begin n_fail++; $display("FAIL limit_rdata: got %h want %h", if_rdata, val); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL limit_no_err: got %b want 0", timeout_err); end
    if_req = 0;
    tick();
    $display("[TB] test_ack_at_limit done in %0d cycles", k);
  endtask

  task automatic test_timeout();
    int k;
    lat_cfg = 0;
    if_req = 1; if_addr = 32'h30;
    k = 0;
    do begin tick(); k++; end while (!if_ready && k < 40);
    n_tests++; if (k !== MAX_WAIT + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", k, MAX_WAIT + 2); end
    n_tests++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0", if_rdata); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
    if_req = 0;
    tick();
    lat_cfg = 1;
    if_req = 1; if_addr = 32'h3C;
    k = 0;
    do begin tick(); k++; end while (!if_ready && k < 10);
    n_tests++; if (if_rdata !== mem_arr[idx(32'h3C)]) begin n_fail++; $display("FAIL timeout_recover_rdata: got %h want %h", if_rdata, mem_arr[idx(32'h3C)]); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", timeout_err); end
    if_req = 0;
    tick();
    $display("[TB] test_timeout done");
  endtask

  task automatic test_starvation();
    int nst, k;
    bit if_done;
    logic [31:0] wd [0:4];
    for (int i = 0; i < 5; i++) wd[i] = $urandom;
    lat_cfg = 1;
    nst = 0; if_done = 0;
    if_req = 1; if_addr = 32'h60;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = wd[0];
    k = 0;
    while ((nst < 5 || !if_done) && k < 200) begin
      tick(); k++;
      n_tests++; if (mem_req !== m_req) begin n_fail++; $display("FAIL starve_mem_req: got %b want %b", mem_req, m_req); end
      if (m_req) begin
        n_tests++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL starve_grant_addr: got %h want %h", mem_addr, m_addr); end
      end
      n_tests++; if (if_ready !== m_if_rdy || dm_ready !== m_dm_rdy) begin n_fail++; $display("FAIL starve_ready: got %b/%b want %b/%b", if_ready, dm_ready, m_if_rdy, m_dm_rdy); end
      if (m_dm_rdy) begin
        nst++;
        if (nst < 5) begin dm_addr = 32'h200 + 32'(4 * nst); dm_wdata = wd[nst]; end
        else dm_req = 0;
      end
      if (m_if_rdy) begin if_req = 0; if_done = 1; end
    end
    n_tests++; if (nst !== 5 || !if_done) begin n_fail++; $display("FAIL starve_completion: got stores=%0d if_done=%0d want 5/1", nst, if_done); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (mem_arr[idx(32'h200 + 32'(4 * i))] !== wd[i]) begin n_fail++; $display("FAIL starve_store_data: got %h want %h slot %0d", mem_arr[idx(32'h200 + 32'(4 * i))], wd[i], i); end
    end
    tick();
    // counter must be back near zero: a fresh tie now goes to data
    if_req = 1; if_addr = 32'h64; dm_req = 1; dm_we = 0; dm_addr = 32'h204;
    tick();
    n_tests++; if (mem_addr !== 32'h204) begin n_fail++; $display("FAIL starve_cleared: got %h want 00000204", mem_addr); end
    k = 0;
    while ((if_req || dm_req) && k < 50) begin
      tick(); k++;
      if (m_if_rdy) if_req = 0;
      if (m_dm_rdy) dm_req = 0;
    end
    tick();
    $display("[TB] test_starvation done in %0d cycles", k);
  endtask

  task automatic test_random();
    junk_idle = 1;
    for (int c = 0; c < 400; c++) begin
      tick();
      n_tests++; if (mem_req !== m_req) begin n_fail++; $display("FAIL rand_mem_req: got %b want %b cyc %0d", mem_req, m_req, c); end
      if (m_req) begin
        n_tests++; if (mem_addr !== m_addr || mem_we !== m_we) begin n_fail++; $display("FAIL rand_mem_addr_we: got %h/%b want %h/%b cyc %0d", mem_addr, mem_we, m_addr, m_we, c); end
        if (m_we) begin
          n_tests++; if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rand_mem_wdata: got %h want %h cyc %0d", mem_wdata, m_wdata, c); end
        end
      end
      n_tests++; if (if_ready !== m_if_rdy || dm_ready !== m_dm_rdy) begin n_fail++; $display("FAIL rand_ready: got %b/%b want %b/%b cyc %0d", if_ready, dm_ready, m_if_rdy, m_dm_rdy, c); end
      n_tests++; if (if_rdata !== m_if_rdata || dm_rdata !== m_dm_rdata) begin n_fail++; $display("FAIL rand_rdata: got %h/%h want %h/%h cyc %0d", if_rdata, dm_rdata, m_if_rdata, m_dm_rdata, c); end
      n_tests++; if (timeout_err !== m_terr) begin n_fail++; $display("FAIL rand_timeout_err: got %b want %b cyc %0d", timeout_err, m_terr, c); end
      // new stimulus: requests stay put until served
      if (!if_req || m_if_rdy) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = {22'h0, 8'($urandom), 2'b00};
      end
      if (!dm_req || m_dm_rdy) begin
        dm_req = ($urandom_range(0, 2) == 0);
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = {22'h0, 8'($urandom), 2'b00};
        dm_wdata = $urandom;
      end
      if (!m_req) lat_cfg = ($urandom_range(0, 60) == 0) ? 0 : $urandom_range(1, 4);
      #1;
      n_tests++; if (stall !== ((if_req && !m_if_rdy) || (dm_req && !m_dm_rdy))) begin n_fail++; $display("FAIL rand_stall: got %b cyc %0d", stall, c); end
    end
    if_req = 0; dm_req = 0; junk_idle = 0; lat_cfg = 1;
    for (int c = 0; c < 40; c++) tick();
    $display("[TB] test_random done");
  endtask

  task automatic test_reset_mid();
    junk_idle = 0; lat_cfg = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    tick(); tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", mem_req); end
    rst = 1;
    tick();
    rst = 0; dm_req = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    n_tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req_we: got %b/%b want 0/0", mem_req, mem_we); end
    n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_mem_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_tests++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    n_tests++; if (if_ready !== 1'b0 || dm_ready !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b/%b/%b want 0/0/0", if_ready, dm_ready, timeout_err); end
    tick();
    n_tests++; if (dm_ready !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_ack_ignored: got ready %b req %b rdata %h want 0/0/0", dm_ready, mem_req, dm_rdata); end
    mem_ack = 0;
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    model_reset();
    #1;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_ack_at_limit();
    test_timeout();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
